// File: rtl/shift_sub_div_pkg.sv
// Shared types and defaults for the shift_sub_div restoring divider.
// FSM state encoding lives here so the top and the bench agree on it.
package shift_sub_div_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sub_div_step.sv
// One combinational restoring-division iteration:
// shift in a dividend bit, then subtract the divisor if it fits.
module shift_sub_div_step
    import shift_sub_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dvs_ext;

    assign dvs_ext = {1'b0, dvs_i};
    assign shifted = (rem_i << 1) | {{WIDTH{1'b0}}, dvd_bit_i};

    always_comb begin
        q_bit_o = 1'b0;
        rem_o   = shifted;
        if (shifted >= dvs_ext) begin
            q_bit_o = 1'b1;
            rem_o   = shifted - dvs_ext;
        end
    end

endmodule

// File: rtl/shift_sub_div.sv
// Restoring shift-subtract divider, one quotient bit per cycle, MSB first.
// Optional macro DIV_ZERO_FLAG_EN adds o_divZero and a 1-cycle zero-divisor exit.
module shift_sub_div
    import shift_sub_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_busy,
`ifdef DIV_ZERO_FLAG_EN
    output logic             o_divZero,
`endif
    output logic             o_done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rmd_q;

    logic [WIDTH:0]   rem_d;
    logic             q_bit;
    logic [WIDTH-1:0] dvd_d;

    // dvd_q shifts the dividend out at the top and collects quotient bits below
    assign dvd_d = {dvd_q[WIDTH-2:0], q_bit};

    shift_sub_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .dvd_bit_i(dvd_q[WIDTH-1]),
        .dvs_i    (dvs_q),
        .rem_o    (rem_d),
        .q_bit_o  (q_bit)
    );

`ifdef DIV_ZERO_FLAG_EN
    logic div0_q;
    assign o_divZero = div0_q;
`endif

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rmd_q   <= '0;
`ifdef DIV_ZERO_FLAG_EN
            div0_q  <= 1'b0;
`endif
        end else if (i_start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= i_dividend;
            dvs_q   <= i_divisor;
        end else begin
            case (state_q)
                RUN: begin
`ifdef DIV_ZERO_FLAG_EN
                    if (dvs_q == '0) begin
                        state_q <= DONE;
                        quot_q  <= '1;
                        rmd_q   <= dvd_q;
                        div0_q  <= 1'b1;
                    end else
`endif
                    begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_q <= DONE;
                            quot_q  <= dvd_d;
                            rmd_q   <= rem_d[WIDTH-1:0];
`ifdef DIV_ZERO_FLAG_EN
                            div0_q  <= 1'b0;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_quotient  = quot_q;
    assign o_remainder = rmd_q;
    assign o_busy      = (state_q == RUN);
    assign o_done      = (state_q == DONE);

endmodule

// File: tb/tb_shift_sub_div.sv
// Scoreboard bench for shift_sub_div (WIDTH=8).
// Build with or without DIV_ZERO_FLAG_EN to match the RTL.
module tb_shift_sub_div;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    logic         i_clk = 1'b0;
    logic         i_arst_n = 1'b0;
    logic         i_start = 1'b0;
    logic [W-1:0] i_dividend = '0;
    logic [W-1:0] i_divisor = '0;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_busy;
    logic         o_done;
`ifdef DIV_ZERO_FLAG_EN
    logic         o_divZero;
`endif

    shift_sub_div #(
        .WIDTH(W)
    ) dut (
        .i_clk      (i_clk),
        .i_arst_n   (i_arst_n),
        .i_start    (i_start),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_quotient (o_quotient),
        .o_remainder(o_remainder),
        .o_busy     (o_busy),
`ifdef DIV_ZERO_FLAG_EN
        .o_divZero  (o_divZero),
`endif
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit track);
        exp_t e;
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        if (track) begin
            e.dz  = 1'b0;
            e.lat = W;
            if (b == 0) begin
                e.q = '1;
                e.r = a;
`ifdef DIV_ZERO_FLAG_EN
                e.dz  = 1'b1;
                e.lat = 1;
`endif
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
            sb.push_back(e);
        end
        tick();
        i_start    = 1'b0;
        i_dividend = W'($urandom);
        i_divisor  = W'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        exp_t e;
        while (o_done !== 1'b1 && n < 20) begin
            chk("busy_run", o_busy, 1);
            chk("hold_q", o_quotient, last_q);
            chk("hold_r", o_remainder, last_r);
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty no expected result queued");
            return;
        end
        e = sb.pop_front();
        chk("latency", n, e.lat);
        chk("done", o_done, 1);
        chk("busy_done", o_busy, 0);
        chk("quot", o_quotient, e.q);
        chk("rem", o_remainder, e.r);
`ifdef DIV_ZERO_FLAG_EN
        chk("divzero", o_divZero, e.dz);
`endif
        last_q = e.q;
        last_r = e.r;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_q"}, o_quotient, 0);
        chk({tag, "_r"}, o_remainder, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
`ifdef DIV_ZERO_FLAG_EN
        chk({tag, "_dz"}, o_divZero, 0);
`endif
    endtask

    initial begin
        #3;
        chk_zero("reset");
        tick();
        i_arst_n = 1'b1;
        tick();
        chk_zero("idle");

        start_div(8'd200, 8'd7, 1'b1);
        wait_done();
        start_div(8'd255, 8'd1, 1'b1);
        wait_done();
        start_div(8'd5, 8'd9, 1'b1);
        wait_done();
        start_div(8'd37, 8'd0, 1'b1);
        wait_done();

        // restart mid-run: the abandoned result must never appear
        start_div(8'd100, 8'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("restart_nodone", o_done, 0);
            tick();
        end
        start_div(8'd50, 8'd6, 1'b1);
        wait_done();

        for (int i = 0; i < 20; i++) begin
            chk("hold_done", o_done, 1);
            chk("hold_dq", o_quotient, last_q);
            chk("hold_dr", o_remainder, last_r);
            tick();
        end

        start_div(8'd200, 8'd7, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        #2;
        i_arst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        tick();
        tick();
        chk_zero("rst_held");
        i_arst_n = 1'b1;
        last_q = '0;
        last_r = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_zero("post_rst");
        end
        start_div(8'd81, 8'd9, 1'b1);
        wait_done();

        for (int i = 0; i < 8; i++) begin
            start_div(W'($urandom_range(0, 255)), W'($urandom_range(1, 255)),
                      1'b1);
            wait_done();
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover %0d entries", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
